// File: rtl/uart_frame_tx_arbiter.sv
// Round-robin arbiter sharing one byte-level uart_tx between NUM_REQ requesters, framing each string as &&payload&&.
// Define UART_ARB_CHECKSUM_EN to insert an XOR checksum byte between the payload and the trailing &&.
module uart_frame_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [8*NUM_REQ-1:0]           req_len,
  input  logic [8*MAX_LEN*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [7:0]                     uart_tx_data,
  output logic                           uart_tx_req,
  input  logic                           uart_tx_done
);

  localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int         PW        = 8 * MAX_LEN;
  localparam logic [7:0] AMP       = 8'h26;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
`ifdef UART_ARB_CHECKSUM_EN
  localparam logic [7:0] TAIL      = 8'd4;
`else
  localparam logic [7:0] TAIL      = 8'd3;
`endif

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, FINISH} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [7:0]         len_q;
  logic [7:0]         last_q;
  logic [7:0]         cnt_q;
  logic [7:0]         tx_data_q;
  logic               tx_req_q;
  logic [PW-1:0]      pay_q;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]         csum_q;
  logic [7:0]         csum_d;
`endif

  logic [IDX_W-1:0]   win;
  logic               found;
  logic [7:0]         sel_len;
  logic [7:0]         clamp_len;
  logic [PW-1:0]      sel_data;
  logic [7:0]         byte_idx;
  logic [7:0]         pay_idx;
  logic [7:0]         next_byte;

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin : win_search
    int j;
    // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latch).
    j     = 0;
    win   = ptr_q;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[j]) begin
        win   = IDX_W'(j);
        found = 1'b1;
      end
    end
  end

  assign sel_len   = req_len[8*idx_q +: 8];
  assign sel_data  = req_data[PW*idx_q +: PW];
  assign clamp_len = (sel_len > MAX_LEN_B) ? MAX_LEN_B : sel_len;

`ifdef UART_ARB_CHECKSUM_EN
  always_comb begin : csum_calc
    csum_d = 8'h00;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (8'(k) < clamp_len) csum_d = csum_d ^ sel_data[8*k +: 8];
    end
  end
`endif

  // Byte to present next: index 0 when launching from GRANT, otherwise the one after cnt_q.
  always_comb begin : byte_sel
    byte_idx  = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
    pay_idx   = byte_idx - 8'd2;
    next_byte = AMP;
    if (byte_idx >= 8'd2 && pay_idx < len_q) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (pay_idx == 8'(k)) next_byte = pay_q[8*k +: 8];
      end
    end
`ifdef UART_ARB_CHECKSUM_EN
    else if (byte_idx >= 8'd2 && pay_idx == len_q) begin
      next_byte = csum_q;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      len_q     <= 8'd0;
      last_q    <= 8'd0;
      cnt_q     <= 8'd0;
      tx_data_q <= 8'h00;
      tx_req_q  <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      tx_req_q <= 1'b0;
      done_q   <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            idx_q   <= win;
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          ptr_q     <= IDX_W'((int'(idx_q) + 1) % NUM_REQ);
          len_q     <= clamp_len;
          last_q    <= clamp_len + TAIL;
          cnt_q     <= 8'd0;
`ifdef UART_ARB_CHECKSUM_EN
          csum_q    <= csum_d;
`endif
          tx_data_q <= next_byte;
          tx_req_q  <= 1'b1;
          state_q   <= SEND;
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (uart_tx_done) begin
            if (cnt_q == last_q) begin
              done_q  <= gnt_q;
              state_q <= FINISH;
            end else begin
              cnt_q     <= cnt_q + 8'd1;
              tx_data_q <= next_byte;
              tx_req_q  <= 1'b1;
              state_q   <= SEND;
            end
          end
        end
        FINISH: begin
          gnt_q   <= '0;
          cnt_q   <= 8'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the payload snapshot is pure datapath, always rewritten in GRANT before use, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (state_q == GRANT) pay_q <= sel_data;
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign uart_tx_data = tx_data_q;
  assign uart_tx_req  = tx_req_q;

endmodule

// File: tb/tb_uart_frame_tx_arbiter.sv
// Scoreboard bench for uart_frame_tx_arbiter: stimulus queues expected bytes/dones, a monitor compares them.
module tb_uart_frame_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAX_LEN = 16;
  localparam int PW      = 8 * MAX_LEN;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] gnt;
  } exp_t;

  logic                         sys_clk = 1'b0;
  logic                         sys_rst_n = 1'b1;
  logic [NUM_REQ-1:0]           req;
  logic [8*NUM_REQ-1:0]         req_len;
  logic [PW*NUM_REQ-1:0]        req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic [7:0]                   uart_tx_data;
  logic                         uart_tx_req;
  logic                         uart_tx_done;
  logic                         model_done = 1'b0;
  logic                         stray_done = 1'b0;

  exp_t       exp_q[$];
  logic [3:0] done_exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rx_count = 0;
  int         done_seen = 0;
  int         last_done = 0;
  int         gap_en = 0;
  int         gap_pend = 0;
  int         base;
  exp_t       mon_e;
  logic [3:0] mon_d;
  logic       outstanding = 1'b0;
  int         tx_cnt = 0;

  assign uart_tx_done = model_done | stray_done;

  always #5 sys_clk = ~sys_clk;

  uart_frame_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .uart_tx_data (uart_tx_data),
    .uart_tx_req  (uart_tx_req),
    .uart_tx_done (uart_tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b);
    exp_t e;
    e.data = b;
    e.gnt  = 4'(1 << r);
    exp_q.push_back(e);
  endtask

  // Hand-written frame: first byte in the most significant of the n low bytes of v.
  task automatic push_lit(input int r, input int n, input logic [8*24-1:0] v);
    for (int i = 0; i < n; i++) push_byte(r, v[8*(n-1-i) +: 8]);
    done_exp_q.push_back(4'(1 << r));
  endtask

  // Reference framing: clamp, && payload [xor] &&.
  task automatic push_model(input int r, input int len, input logic [PW-1:0] p);
    int         n;
    logic [7:0] cs;
    n  = (len > MAX_LEN) ? MAX_LEN : len;
    cs = 8'h00;
    push_byte(r, 8'h26);
    push_byte(r, 8'h26);
    for (int k = 0; k < n; k++) begin
      push_byte(r, p[8*k +: 8]);
      cs = cs ^ p[8*k +: 8];
    end
`ifdef UART_ARB_CHECKSUM_EN
    push_byte(r, cs);
`endif
    push_byte(r, 8'h26);
    push_byte(r, 8'h26);
    done_exp_q.push_back(4'(1 << r));
  endtask

  task automatic set_req(input int r, input int len, input logic [PW-1:0] p);
    req_len[8*r +: 8]   = 8'(len);
    req_data[PW*r +: PW] = p;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int   n = 0;
    logic pend;
    pend = 1'b1;
    while (pend && n < 3000) begin
      @(negedge sys_clk);
      n++;
      pend = busy || (exp_q.size() != 0) || (done_exp_q.size() != 0);
    end
    check(name, {31'b0, pend}, 32'd0);
  endtask

  task automatic idle_gap();
    repeat (12) @(negedge sys_clk);
  endtask

  // Byte-level UART stand-in: completes each byte four cycles after its start pulse.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      outstanding = 1'b0;
      model_done  = 1'b0;
    end else begin
      model_done = 1'b0;
      if (outstanding) begin
        if (tx_cnt == 0) begin
          model_done  = 1'b1;
          outstanding = 1'b0;
        end else begin
          tx_cnt--;
        end
      end
      if (uart_tx_req) begin
        check("no_overlap", {31'b0, outstanding}, 32'd0);
        outstanding = 1'b1;
        tx_cnt      = 3;
      end
    end
  end

  always @(negedge sys_clk) begin
    cyc++;
    if (gap_pend != 0 && cyc - last_done > 10) gap_pend = 0;
    if (sys_rst_n && uart_tx_req) begin
      rx_count++;
      if (gap_pend != 0) begin
        if (gap_en != 0) check("frame_gap", cyc - last_done, 32'd3);
        gap_pend = 0;
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_byte: got %02h expected none", uart_tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_byte", {24'b0, uart_tx_data}, {24'b0, mon_e.data});
        check("tx_gnt", {28'b0, gnt}, {28'b0, mon_e.gnt});
      end
    end
    if (sys_rst_n && done != 0) begin
      done_seen++;
      last_done = cyc;
      gap_pend  = 1;
      if (done_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got %0h expected none", done);
      end else begin
        mon_d = done_exp_q.pop_front();
        check("done", {28'b0, done}, {28'b0, mon_d});
      end
    end
  end

  initial begin
    req      = '0;
    req_len  = '0;
    req_data = '0;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_done", {28'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", {24'b0, uart_tx_data}, 32'd0);
    check("rst_req", {31'b0, uart_tx_req}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // uart_tx_done while idle must be ignored
    stray_done = 1'b1;
    @(negedge sys_clk);
    stray_done = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      check("stray_busy", {31'b0, busy}, 32'd0);
    end

    // basic frame "abc" on requester 0, with cycle-exact launch
    set_req(0, 3, {8'h63, 8'h62, 8'h61});
`ifdef UART_ARB_CHECKSUM_EN
    push_lit(0, 8, {8'h26, 8'h26, 8'h61, 8'h62, 8'h63, 8'h60, 8'h26, 8'h26});
`else
    push_lit(0, 7, {8'h26, 8'h26, 8'h61, 8'h62, 8'h63, 8'h26, 8'h26});
`endif
    req = 4'b0001;
    @(negedge sys_clk);
    check("t1_gnt", {28'b0, gnt}, 32'h1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    @(negedge sys_clk);
    check("t2_req", {31'b0, uart_tx_req}, 32'd1);
    check("t2_data", {24'b0, uart_tx_data}, 32'h26);
    req = 4'b0000;
    wait_idle("basic_idle");
    idle_gap();

    // empty payload on requester 2
    set_req(2, 0, '0);
`ifdef UART_ARB_CHECKSUM_EN
    push_lit(2, 5, {8'h26, 8'h26, 8'h00, 8'h26, 8'h26});
`else
    push_lit(2, 4, {8'h26, 8'h26, 8'h26, 8'h26});
`endif
    req = 4'b0100;
    wait_busy("len0_busy");
    check("len0_gnt", {28'b0, gnt}, 32'h4);
    req = 4'b0000;
    wait_idle("len0_idle");
    idle_gap();

    // over-long length clamps to MAX_LEN on requester 3
    set_req(3, 20, 128'h3F3E3D3C3B3A39383736353433323130);
    push_model(3, 20, 128'h3F3E3D3C3B3A39383736353433323130);
    base = rx_count;
    req = 4'b1000;
    wait_busy("len20_busy");
    req = 4'b0000;
    wait_idle("len20_idle");
`ifdef UART_ARB_CHECKSUM_EN
    check("len20_bytes", rx_count - base, 32'd21);
`else
    check("len20_bytes", rx_count - base, 32'd20);
`endif
    idle_gap();

    // round robin with all requests held: order 0,1,2,3,0
    set_req(0, 1, 128'h41);
    set_req(1, 2, 128'h4342);
    set_req(2, 1, 128'h44);
    set_req(3, 2, 128'h4645);
    push_model(0, 1, 128'h41);
    push_model(1, 2, 128'h4342);
    push_model(2, 1, 128'h44);
    push_model(3, 2, 128'h4645);
    push_model(0, 1, 128'h41);
    gap_en = 1;
    base = done_seen;
    req = 4'b1111;
    for (int n = 0; n < 2000 && done_seen < base + 4; n++) @(negedge sys_clk);
    check("rr_dones", done_seen - base, 32'd4);
    wait_busy("rr5_busy");
    check("rr5_gnt", {28'b0, gnt}, 32'h1);
    req = 4'b0000;
    wait_idle("rr_idle");
    gap_en = 0;
    idle_gap();

    // snapshot: inputs change one cycle after GRANT
    set_req(0, 3, {8'h5A, 8'h59, 8'h58});
    push_model(0, 3, {8'h5A, 8'h59, 8'h58});
    req = 4'b0001;
    wait_busy("snap_busy");
    @(negedge sys_clk);
    set_req(0, 1, {8'h51, 8'h51, 8'h51});
    req = 4'b0000;
    wait_idle("snap_idle");
    idle_gap();

`ifdef UART_ARB_CHECKSUM_EN
    // checksum equal to the framing character
    set_req(1, 2, {8'h34, 8'h12});
    push_lit(1, 7, {8'h26, 8'h26, 8'h12, 8'h34, 8'h26, 8'h26, 8'h26});
    req = 4'b0010;
    wait_busy("cs_busy");
    req = 4'b0000;
    wait_idle("cs_idle");
    idle_gap();
`endif

    // reset after the 3rd byte: no done, outputs back to reset values
    set_req(1, 5, {8'h65, 8'h64, 8'h63, 8'h62, 8'h61});
    push_byte(1, 8'h26);
    push_byte(1, 8'h26);
    push_byte(1, 8'h61);
    req = 4'b0010;
    wait_busy("rst_busy_on");
    req = 4'b0000;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge sys_clk);
    check("rst_3bytes", exp_q.size(), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("mid_gnt", {28'b0, gnt}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_data", {24'b0, uart_tx_data}, 32'd0);
    repeat (3) @(negedge sys_clk);
    check("mid_done", {28'b0, done}, 32'd0);
    check("mid_req", {31'b0, uart_tx_req}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // pointer back at 0: requesters 1 and 3 pending, 1 wins
    set_req(3, 1, 128'h77);
    push_model(1, 5, {8'h65, 8'h64, 8'h63, 8'h62, 8'h61});
    req = 4'b1010;
    wait_busy("post_busy");
    check("post_gnt", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    wait_idle("post_idle");

    check("exp_left", exp_q.size(), 32'd0);
    check("done_left", done_exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
